instr_fetch_unit: RTL and testbench

//  Fetch stage feeding the opcode decoder: owns the PC, reads 16-bit instruction words from instruction memory

---
 rtl/instr_fetch_unit.sv | 156 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, fetches instruction words over a req/ack handshake and
// buffers them in a small prefetch FIFO presented to decode with valid/ready.
module instr_fetch_unit #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 2,
  parameter int RESET_PC   = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [3:0]        opcode,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_FULL, S_FLUSH} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [DATA_W-1:0] r_buf_instr [FIFO_DEPTH];
  logic [ADDR_W-1:0] r_buf_pc    [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_ack;
  logic              w_push;
  logic              w_pop;
  logic              w_valid;
  logic              w_slot_free;

  assign w_ack       = imem_req & imem_ack;
  assign w_valid     = (r_count != '0);
  assign w_pop       = w_valid & instr_ready;
  // Data returning during FLUSH or in a redirect cycle belongs to the abandoned path.
  assign w_push      = w_ack & (r_state == S_FETCH) & ~redirect;
  assign w_slot_free = (w_cnt_nxt < CNT_W'(FIFO_DEPTH));

  always_comb begin
    w_cnt_nxt = r_count;
    if (w_push && !w_pop) begin
      w_cnt_nxt = r_count + 1'b1;
    end else if (!w_push && w_pop) begin
      w_cnt_nxt = r_count - 1'b1;
    end
  end

  assign instr_valid = w_valid;
  assign instr       = w_valid ? r_buf_instr[r_rd_ptr] : '0;
  assign instr_pc    = w_valid ? r_buf_pc[r_rd_ptr] : '0;
  assign opcode      = instr[DATA_W-1 -: 4];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_instr[r_wr_ptr] <= imem_rdata;
      r_buf_pc[r_wr_ptr]    <= r_fetch_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || redirect) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      imem_req   <= 1'b0;
      imem_addr  <= ADDR_W'(RESET_PC);
      r_fetch_pc <= ADDR_W'(RESET_PC);
    end else if (redirect) begin
      r_fetch_pc <= redirect_pc;
      // An unanswered request must still complete at its old address before restarting.
      if (imem_req && !imem_ack) begin
        r_state <= S_FLUSH;
      end else if (halt) begin
        r_state  <= S_IDLE;
        imem_req <= 1'b0;
      end else begin
        r_state   <= S_FETCH;
        imem_req  <= 1'b1;
        imem_addr <= redirect_pc;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!halt && w_slot_free) begin
            r_state   <= S_FETCH;
            imem_req  <= 1'b1;
            imem_addr <= r_fetch_pc;
          end
        end
        S_FETCH: begin
          if (w_ack) begin
            r_fetch_pc <= r_fetch_pc + 1'b1;
            if (halt) begin
              r_state  <= S_IDLE;
              imem_req <= 1'b0;
            end else if (w_slot_free) begin
              imem_addr <= r_fetch_pc + 1'b1;
            end else begin
              r_state  <= S_FULL;
              imem_req <= 1'b0;
            end
          end
        end
        S_FULL: begin
          if (w_slot_free) begin
            if (halt) begin
              r_state <= S_IDLE;
            end else begin
              r_state   <= S_FETCH;
              imem_req  <= 1'b1;
              imem_addr <= r_fetch_pc;
            end
          end
        end
        S_FLUSH: begin
          if (w_ack) begin
            if (halt) begin
              r_state  <= S_IDLE;
              imem_req <= 1'b0;
            end else begin
              r_state   <= S_FETCH;
              imem_addr <= r_fetch_pc;
            end
          end
        end
        default: begin
          r_state  <= S_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: behavioural instruction memory with programmable
// ack delay, delivery/handshake logging, and hand-computed expectations per scenario.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [3:0]  opcode;
  logic [7:0]  instr_pc;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic        halt;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int mem_dly = 1;
  int m_cnt = 0;
  int rc;
  logic [7:0] q_pc[$];
  logic [7:0] q_ack[$];
  logic [7:0] t4_exp [4];

  instr_fetch_unit #(
    .DATA_W(16), .ADDR_W(8), .FIFO_DEPTH(2), .RESET_PC(0)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .opcode(opcode),
    .instr_pc(instr_pc), .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory content: low byte is the address, top nibble repeats its low nibble.
  function automatic logic [15:0] exp_word(input logic [7:0] a);
    return {a[3:0], 4'h0, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) step();
    q_pc.delete();
    q_ack.delete();
    rst = 1'b0;
  endtask

  // Instruction memory: answers a held request after mem_dly cycles.
  always @(posedge clk) begin
    if (rst) begin
      imem_ack <= 1'b0;
      m_cnt    <= 0;
    end else if (imem_ack) begin
      imem_ack <= 1'b0;
      m_cnt    <= 0;
    end else if (imem_req) begin
      if (m_cnt + 1 >= mem_dly) begin
        imem_ack   <= 1'b1;
        imem_rdata <= exp_word(imem_addr);
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end else begin
      m_cnt <= 0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (instr_valid && instr_ready) begin
        q_pc.push_back(instr_pc);
        chk("mon_data", instr, exp_word(instr_pc));
        chk("mon_opcode", opcode, instr_pc[3:0]);
      end
      if (imem_req && imem_ack) q_ack.push_back(imem_addr);
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; instr_ready = 1'b1; redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
    imem_rdata = '0;
    t4_exp = '{8'hFE, 8'hFF, 8'h00, 8'h01};

    // 1: reset values, first-word latency, in-order streaming
    repeat (3) step();
    @(negedge clk);
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_opcode", opcode, 0);
    chk("rst_pc", instr_pc, 0);
    step();
    q_pc.delete(); q_ack.delete();
    rst = 1'b0;
    for (int i = 0; i < 50 && !imem_req; i++) @(negedge clk);
    chk("t1_req_seen", imem_req, 1);
    chk("t1_first_addr", imem_addr, 0);
    rc = cyc;
    for (int i = 0; i < 50 && !instr_valid; i++) @(negedge clk);
    chk("t1_latency", cyc - rc, 2);
    chk("t1_first_pc", instr_pc, 0);
    repeat (14) step();
    chk("t1_count", q_pc.size() >= 6, 1);
    for (int i = 0; i < 6; i++) chk("t1_order", q_pc[i], i);

    // 2: decoder stall fills the buffer, then drains and refetches
    instr_ready = 1'b0; mem_dly = 1;
    do_reset();
    repeat (12) @(negedge clk);
    chk("t2_req_low", imem_req, 0);
    chk("t2_valid", instr_valid, 1);
    chk("t2_head_pc", instr_pc, 0);
    chk("t2_head_instr", instr, exp_word(8'h00));
    chk("t2_acks", q_ack.size(), 2);
    chk("t2_none_popped", q_pc.size(), 0);
    step();
    instr_ready = 1'b1;
    @(negedge clk);
    chk("t2_pop_req", imem_req, 0);
    chk("t2_pop_pc", instr_pc, 0);
    @(negedge clk);
    chk("t2_refetch_req", imem_req, 1);
    chk("t2_refetch_addr", imem_addr, 2);
    chk("t2_second_pc", instr_pc, 1);
    repeat (10) step();
    chk("t2_count", q_pc.size() >= 4, 1);
    for (int i = 0; i < 4; i++) chk("t2_order", q_pc[i], i);

    // 3: redirect while the request at 5 is outstanding
    instr_ready = 1'b1; mem_dly = 3;
    do_reset();
    for (int i = 0; i < 200 && !(imem_req && imem_addr == 8'h05); i++) @(negedge clk);
    chk("t3_req5_seen", imem_req && imem_addr == 8'h05, 1);
    step();
    redirect = 1'b1; redirect_pc = 8'h40;
    @(negedge clk);
    chk("t3_pre_count", q_pc.size(), 5);
    step();
    redirect = 1'b0;
    @(negedge clk);
    chk("t3_flush_valid", instr_valid, 0);
    chk("t3_flush_req", imem_req, 1);
    chk("t3_flush_addr", imem_addr, 5);
    repeat (2) @(negedge clk);
    chk("t3_new_req", imem_req, 1);
    chk("t3_new_addr", imem_addr, 8'h40);
    for (int i = 0; i < 100 && q_pc.size() < 6; i++) step();
    chk("t3_count", q_pc.size(), 6);
    chk("t3_last_old", q_pc[4], 4);
    chk("t3_target", q_pc[5], 8'h40);

    // 4: PC wraps from FF to 00
    halt = 1'b1; mem_dly = 1; instr_ready = 1'b1;
    do_reset();
    redirect = 1'b1; redirect_pc = 8'hFE;
    step();
    redirect = 1'b0; halt = 1'b0;
    @(negedge clk);
    chk("t4_halt_idle", imem_req, 0);
    repeat (14) step();
    chk("t4_count", q_pc.size() >= 4, 1);
    for (int i = 0; i < 4; i++) chk("t4_pc", q_pc[i], t4_exp[i]);
    for (int i = 0; i < 3; i++) chk("t4_addr", q_ack[i], t4_exp[i]);

    // 5: halt mid-stream lets the outstanding word through, then resumes
    halt = 1'b0; mem_dly = 3; instr_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 200 && !(imem_req && imem_addr == 8'h03); i++) @(negedge clk);
    chk("t5_req3_seen", imem_req && imem_addr == 8'h03, 1);
    step();
    halt = 1'b1;
    repeat (4) @(negedge clk);
    chk("t5_req_dropped", imem_req, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t5_no_req", imem_req, 0);
    end
    chk("t5_count", q_pc.size(), 4);
    chk("t5_last", q_pc[3], 3);
    step();
    halt = 1'b0;
    @(negedge clk);
    chk("t5_resume_idle", imem_req, 0);
    @(negedge clk);
    chk("t5_resume_req", imem_req, 1);
    chk("t5_resume_addr", imem_addr, 4);
    for (int i = 0; i < 100 && q_pc.size() < 5; i++) step();
    chk("t5_next_pc", q_pc[4], 4);

    // 6: reset while fetching with every slot committed
    instr_ready = 1'b0; mem_dly = 3; halt = 1'b0;
    do_reset();
    for (int i = 0; i < 200 && !(instr_valid && imem_req); i++) @(negedge clk);
    chk("t6_busy_seen", instr_valid && imem_req, 1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_req", imem_req, 0);
    chk("t6_addr", imem_addr, 0);
    chk("t6_valid", instr_valid, 0);
    chk("t6_instr", instr, 0);
    chk("t6_opcode", opcode, 0);
    chk("t6_pc", instr_pc, 0);
    @(negedge clk);
    chk("t6_restart_req", imem_req, 1);
    chk("t6_restart_addr", imem_addr, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
